// File: rtl/led_shift_ctrl.sv
// Serial LED chain sequencer: captures a word, shifts it out MSB-first on a divided clock, then pulses LEDEN.
// Optional auto-refresh timer is built when LED_AUTO_REFRESH_EN is defined.
module led_shift_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DIV     = 2,
  parameter int REFRESH = 1048576
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_led_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ledclk,
  output logic             o_ledsout,
  output logic             o_ledclrn,
  output logic             o_leden,
  output logic [2:0]       o_state
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LO    = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit;
  logic [DW-1:0]    r_div;
  logic             r_busy, r_done, r_ledclk, r_ledsout, r_ledclrn, r_leden;
  logic             w_busy, w_done, w_ledclk, w_ledsout, w_leden;
  logic             w_div_last, w_abort, w_auto, w_accept;

  assign w_div_last = (r_div == DW'(DIV - 1));
  assign w_abort    = !i_en && (r_state != S_IDLE);
  assign w_accept   = (r_state == S_IDLE) && i_en && (i_start || w_auto);

`ifdef LED_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH);
  logic [RW-1:0] r_refresh;

  assign w_auto = (r_refresh == RW'(REFRESH - 1));

  // A terminal count while busy is simply dropped: the counter restarts either way.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_refresh <= '0;
    else if (!i_en || w_accept || w_auto)  r_refresh <= '0;
    else                                   r_refresh <= r_refresh + 1'b1;
  end
`else
  assign w_auto = 1'b0 && (REFRESH > 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_div   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_shift <= i_led_data;
          r_bit   <= BW'(WIDTH - 1);
          r_div   <= '0;
          r_state <= S_LO;
        end
        S_LO: if (w_div_last) begin
          r_div   <= '0;
          r_state <= S_HI;
        end else r_div <= r_div + 1'b1;
        S_HI: if (w_div_last) begin
          r_div <= '0;
          if (r_bit == '0) r_state <= S_LATCH;
          else begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit   <= r_bit - 1'b1;
            r_state <= S_LO;
          end
        end else r_div <= r_div + 1'b1;
        S_LATCH: if (w_div_last) begin
          r_div   <= '0;
          r_state <= S_DONE;
        end else r_div <= r_div + 1'b1;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pin values follow the state one cycle later, so every pin comes straight from a flop.
  always_comb begin
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_ledclk  = 1'b0;
    w_ledsout = 1'b0;
    w_leden   = 1'b0;
    case (r_state)
      S_LO:    begin w_busy = 1'b1; w_ledsout = r_shift[WIDTH-1]; end
      S_HI:    begin w_busy = 1'b1; w_ledclk = 1'b1; w_ledsout = r_shift[WIDTH-1]; end
      S_LATCH: begin w_busy = 1'b1; w_leden = 1'b1; end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ledclk  <= 1'b0;
      r_ledsout <= 1'b0;
      r_ledclrn <= 1'b0;
      r_leden   <= 1'b0;
    end else begin
      r_ledclrn <= 1'b1;
      r_busy    <= w_busy    && !w_abort;
      r_done    <= w_done    && !w_abort;
      r_ledclk  <= w_ledclk  && !w_abort;
      r_ledsout <= w_ledsout && !w_abort;
      r_leden   <= w_leden   && !w_abort;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_ledclk  = r_ledclk;
  assign o_ledsout = r_ledsout;
  assign o_ledclrn = r_ledclrn;
  assign o_leden   = r_leden;
  assign o_state   = r_state;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Bench for led_shift_ctrl: DUT A (WIDTH=16, DIV=2), DUT B (WIDTH=8, DIV=1),
// and with LED_AUTO_REFRESH_EN a DUT C (WIDTH=8, DIV=1, REFRESH=100).
module tb_led_shift_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_en;
  logic [15:0] a_data;
  logic        a_busy, a_done, a_ledclk, a_ledsout, a_ledclrn, a_leden;
  logic [2:0]  a_state;

  logic        b_start, b_en;
  logic [7:0]  b_data;
  logic        b_busy, b_done, b_ledclk, b_ledsout, b_ledclrn, b_leden;
  logic [2:0]  b_state;

  led_shift_ctrl #(.WIDTH(16), .DIV(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_en(a_en), .i_led_data(a_data),
    .o_busy(a_busy), .o_done(a_done), .o_ledclk(a_ledclk), .o_ledsout(a_ledsout),
    .o_ledclrn(a_ledclrn), .o_leden(a_leden), .o_state(a_state));

  led_shift_ctrl #(.WIDTH(8), .DIV(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_en(b_en), .i_led_data(b_data),
    .o_busy(b_busy), .o_done(b_done), .o_ledclk(b_ledclk), .o_ledsout(b_ledsout),
    .o_ledclrn(b_ledclrn), .o_leden(b_leden), .o_state(b_state));

`ifdef LED_AUTO_REFRESH_EN
  logic        c_start, c_en;
  logic [7:0]  c_data;
  logic        c_busy, c_done, c_ledclk, c_ledsout, c_ledclrn, c_leden;
  logic [2:0]  c_state;

  led_shift_ctrl #(.WIDTH(8), .DIV(1), .REFRESH(100)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_en(c_en), .i_led_data(c_data),
    .o_busy(c_busy), .o_done(c_done), .o_ledclk(c_ledclk), .o_ledsout(c_ledsout),
    .o_ledclrn(c_ledclrn), .o_leden(c_leden), .o_state(c_state));
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit          sel;
    logic [15:0] data;
    int          done_cyc;
    int          busy_n;
    int          leden_n;
    int          rises;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle c means "sampled 1ns after the c-th edge counted from the accept edge".
  task automatic watch(input bit sel, input int first, input int limit,
                       output logic [15:0] word, output int done_cyc, output int busy_n,
                       output int leden_n, output int rises, output int first_busy);
    logic prev, lc, so, bz, le, dn;
    prev = 1'b0; word = '0; done_cyc = -1; busy_n = 0; leden_n = 0; rises = 0; first_busy = -1;
    for (int c = first; c <= limit; c++) begin
      @(posedge clk); #1;
      lc = sel ? b_ledclk  : a_ledclk;
      so = sel ? b_ledsout : a_ledsout;
      bz = sel ? b_busy    : a_busy;
      le = sel ? b_leden   : a_leden;
      dn = sel ? b_done    : a_done;
      if (lc && !prev) begin rises++; word = {word[14:0], so}; end
      prev = lc;
      if (bz) begin busy_n++; if (first_busy < 0) first_busy = c; end
      if (le) leden_n++;
      if (dn) begin done_cyc = c; break; end
    end
  endtask

  task automatic check_frame(input vec_t v, input logic [15:0] word, input int done_cyc,
                             input int busy_n, input int leden_n, input int rises, input int fb);
    logic [15:0] exp_w;
    if (exp_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_empty: got frame %0h expected none", word);
      return;
    end
    exp_w = exp_q.pop_front();
    check("frame_word", word, exp_w);
    check("done_cycle", done_cyc, v.done_cyc);
    check("busy_cycles", busy_n, v.busy_n);
    check("leden_cycles", leden_n, v.leden_n);
    check("ledclk_rises", rises, v.rises);
    check("busy_first", fb, 1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] word;
    int dc, bn, ln, rs, fb;
    @(negedge clk);
    if (v.sel) begin
      b_data = v.data[7:0]; b_start = 1'b1; exp_q.push_back({8'h00, v.data[7:0]});
    end else begin
      a_data = v.data; a_start = 1'b1; exp_q.push_back(v.data);
    end
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    watch(v.sel, 1, 200, word, dc, bn, ln, rs, fb);
    check_frame(v, word, dc, bn, ln, rs, fb);
  endtask

  vec_t vecs[9];
  vec_t va;
  logic [15:0] w;
  int dc, bn, ln, rs, fb, act_cnt;

  initial begin
    vecs[0] = '{1'b0, 16'hA5C3, 67, 66, 2, 16};
    vecs[1] = '{1'b0, 16'h0001, 67, 66, 2, 16};
    vecs[2] = '{1'b0, 16'h8000, 67, 66, 2, 16};
    vecs[3] = '{1'b0, 16'hFFFF, 67, 66, 2, 16};
    vecs[4] = '{1'b0, 16'h0000, 67, 66, 2, 16};
    vecs[5] = '{1'b0, 16'(($urandom_range(0, 65535))), 67, 66, 2, 16};
    vecs[6] = '{1'b1, 16'h0001, 18, 17, 1, 8};
    vecs[7] = '{1'b1, 16'h0080, 18, 17, 1, 8};
    vecs[8] = '{1'b1, 16'h00A5, 18, 17, 1, 8};
    va = vecs[0];

    rst_n = 1'b0;
    a_start = 1'b0; a_en = 1'b1; a_data = '0;
    b_start = 1'b0; b_en = 1'b1; b_data = '0;
`ifdef LED_AUTO_REFRESH_EN
    c_start = 1'b0; c_en = 1'b1; c_data = 8'h3C;
`endif

    #12;
    check("reset_outputs", {a_busy, a_done, a_ledclk, a_ledsout, a_ledclrn, a_leden}, 6'b0);
    check("reset_state", a_state, 3'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_outputs", {a_busy, a_done, a_ledclk, a_ledsout, a_ledclrn, a_leden}, 6'b000010);

    // Asynchronous reset in the middle of an all-ones frame.
    @(negedge clk); a_data = 16'hFFFF; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (30) @(posedge clk);
    #1 check("midframe_busy", a_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("midframe_reset_outputs", {a_busy, a_done, a_ledclk, a_ledsout, a_ledclrn, a_leden}, 6'b0);
    check("midframe_reset_state", a_state, 3'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerelease_outputs", {a_busy, a_done, a_ledclk, a_ledsout, a_ledclrn, a_leden}, 6'b000010);

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // start held for two frames; data changes mid-frame and must not disturb the first.
    @(negedge clk);
    a_data = 16'hA5C3; a_start = 1'b1;
    exp_q.push_back(16'hA5C3);
    exp_q.push_back(16'hFFFF);
    fork
      begin
        repeat (30) @(negedge clk);
        a_data = 16'hFFFF;
        repeat (80) @(negedge clk);
        a_start = 1'b0;
      end
    join_none
    @(posedge clk);
    watch(1'b0, 1, 200, w, dc, bn, ln, rs, fb);
    check_frame(va, w, dc, bn, ln, rs, fb);
    watch(1'b0, 0, 200, w, dc, bn, ln, rs, fb);
    check_frame(va, w, dc, bn, ln, rs, fb);
    repeat (5) @(posedge clk);

    // en dropped during a frame: abort at the next edge, no latch, no done.
    @(negedge clk); a_data = 16'h1234; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (19) @(posedge clk);
    #1 check("abort_busy_before", a_busy, 1'b1);
    @(negedge clk); a_en = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs", {a_busy, a_ledclk, a_leden, a_done}, 4'b0);
    check("abort_state", a_state, 3'd0);
    @(negedge clk); a_start = 1'b1;
    act_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      act_cnt += int'(a_busy) + int'(a_leden) + int'(a_done) + int'(a_ledclk);
    end
    check("start_with_en_low", act_cnt, 0);
    @(negedge clk); a_start = 1'b0; a_en = 1'b1;
    run_frame(vecs[0]);

`ifdef LED_AUTO_REFRESH_EN
    begin
      int rises_q[$];
      int exp_r[4];
      logic prev;
      exp_r = '{101, 201, 251, 351};
      @(negedge clk); c_en = 1'b0;
      @(posedge clk); #1 c_en = 1'b1;
      prev = c_busy;
      for (int c = 1; c <= 360; c++) begin
        @(posedge clk); #1;
        if (c_busy && !prev) rises_q.push_back(c);
        prev = c_busy;
        if (c == 249) c_start = 1'b1;
        if (c == 250) c_start = 1'b0;
      end
      check("auto_frame_count", rises_q.size(), 4);
      for (int i = 0; i < 4; i++)
        check("auto_frame_start", (i < rises_q.size()) ? rises_q[i] : -1, exp_r[i]);
    end
`endif

    if (exp_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/led_shift_ctrl.md
# led_shift_ctrl

Sequencer for the board's serial LED shift-register chain. It captures a parallel LED word on request and shifts it out MSB-first on a divided shift clock, then pulses the output latch enable. It sits between the GPIO/peripheral register (source of the LED word) and the external shift chain pins (ledclk, ledsout, ledclrn, LEDEN). It replaces free-running scan logic with a request/busy/done handshake.

## Interface
- WIDTH, 16, bits per frame (2..32)
- DIV, 2, system cycles per shift-clock half period (>=1)
- REFRESH, 1048576, auto-refresh period in cycles (only with LED_AUTO_REFRESH_EN)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  frame request, sampled in IDLE only
- en  in  1  enable; 0 blocks new frames and aborts an active one
- led_data  in  WIDTH  LED word, captured on accepted start
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame completed
- ledclk  out  1  shift clock to chain
- ledsout  out  1  serial data, MSB first
- ledclrn  out  1  chain clear, active-low
- LEDEN  out  1  latch pulse to chain outputs

## Operation
- Reset values: busy=0, done=0, ledclk=0, ledsout=0, ledclrn=0, LEDEN=0, state=IDLE, shift reg=0.
- ledclrn: registered; 0 during reset, 1 from first clk edge after rst deasserts.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE: if start=1 and en=1 -> capture led_data into shift reg, bit count=WIDTH-1, div count=0, go SHIFT_LO. start with en=0 ignored.
- SHIFT_LO: ledclk=0, ledsout=shift reg MSB; after DIV cycles -> SHIFT_HI.
- SHIFT_HI: ledclk=1, ledsout held; after DIV cycles: if bit count=0 -> LATCH, else shift reg left by 1, bit count-1, -> SHIFT_LO.
- LATCH: ledclk=0, LEDEN=1 for DIV cycles -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in SHIFT_LO, SHIFT_HI, LATCH.
- start while busy: ignored, not queued.
- led_data changes after capture: no effect on current frame.
- en=0 in any non-IDLE state: next edge -> IDLE, ledclk=0, LEDEN=0, busy=0, no done pulse; chain contents undefined, not latched.
- Counters: div count ceil(log2(DIV)) bits, bit count ceil(log2(WIDTH)) bits, no wrap beyond terminal values.

## Timing
- All outputs registered; no combinational input-to-output paths.
- start accepted at edge 0 -> busy=1, ledclk=0, ledsout=data[WIDTH-1] after edge 1.
- Each bit: 2*DIV cycles; ledsout stable DIV cycles before and through ledclk rising edge.
- Shift phase: 2*DIV*WIDTH cycles; latch: DIV cycles.
- done high in cycle 1+2*DIV*WIDTH+DIV after accept (67 for defaults); busy low same cycle.
- Earliest next accept: the cycle after done (start sampled in IDLE).
- Reset mid-frame: immediate return to reset values, asynchronous.

## Configuration
- LED_AUTO_REFRESH_EN defined: internal REFRESH-cycle counter runs while en=1; on terminal count in IDLE, a frame starts as if start=1, using current led_data; counter resets on every accepted frame (manual or auto); en=0 clears counter. If terminal count hits while busy, the refresh is dropped and the counter restarts.
- Not defined: no counter; frames start only on explicit start.

## Test plan
- Reset: rst=0 mid-frame -> all outputs 0 immediately; first edge after release -> ledclrn=1, others 0.
- Single frame, DIV=2, led_data=16'hA5C3, start pulse -> 16 ledclk rising edges, ledsout sampled on them = A5C3 MSB first, LEDEN high 2 cycles, done at cycle 67, busy 1 for cycles 1..66.
- start asserted continuously during frame, led_data changed to 16'hFFFF mid-frame -> shifted word still 16'hA5C3, second frame begins cycle after done, shifts 16'hFFFF.
- en dropped at cycle 20 of a frame -> IDLE next edge, ledclk=0, no LEDEN, no done; start with en=0 -> ignored.
- DIV=1, WIDTH=8, led_data=8'h01 -> ledclk toggles every cycle, only last bit 1, done at cycle 18.
- LED_AUTO_REFRESH_EN, REFRESH=100, en=1, no start -> frames start at cycles 100, then 100 cycles after each accept; with manual start at cycle 50 -> auto frame moves to 150.
